// File: rtl/cic_integrator_mc_pkg.sv
// cic_pkg -- shared types and helpers for the cic_integrator_mc block (rev 1.0).
// Tokens carry a wide signed payload so every stage can detect true wrap events.
`default_nettype none

package cic_pkg;

  localparam logic [2:0] OS_NONE = 3'd0;
  localparam logic [2:0] OS_2    = 3'd1;
  localparam logic [2:0] OS_4    = 3'd2;
  localparam logic [2:0] OS_8    = 3'd3;
  localparam logic [2:0] OS_16   = 3'd4;
  localparam logic [2:0] OS_32   = 3'd5;
  localparam logic [2:0] OS_64   = 3'd6;
  localparam logic [2:0] OS_FULL = 3'd7;

  localparam int TOK_CHW = 8;
  localparam int TOK_DW  = 64;

  typedef struct packed {
    logic                      valid;
    logic [TOK_CHW-1:0]        ch;
    logic signed [TOK_DW-1:0]  data;
  } cic_tok_t;

  // Working accumulator width for an oversampling code; 0 and 7 use the full width.
  function automatic int w_of(input logic [2:0] os_reg, input int idw, input int nstg,
                              input int odw);
    if (os_reg == OS_NONE || os_reg == OS_FULL) return odw;
    return idw + nstg * int'(os_reg);
  endfunction

  // Keep the low w bits and replicate bit w-1 upward (two's-complement wrap).
  function automatic logic signed [TOK_DW-1:0] wrap(input logic signed [TOK_DW-1:0] value,
                                                    input int w);
    int sh;
    sh = TOK_DW - w;
    return (value <<< sh) >>> sh;
  endfunction

endpackage

`default_nettype wire

// File: rtl/cic_integrator_mc_if.sv
// cic_integrator_mc_if -- sample-in / sum-out valid/ready streams (rev 1.0).
// master is the surrounding datapath, slave is the integrator block.
`default_nettype none

interface cic_integrator_mc_if #(
  parameter int IDW = 16,
  parameter int ODW = 40,
  parameter int CHW = 2
);
  logic           in_valid;
  logic           in_ready;
  logic [CHW-1:0] in_ch;
  logic [IDW-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [CHW-1:0] out_ch;
  logic [ODW-1:0] out_data;

  modport master (
    output in_valid, in_ch, in_data, out_ready,
    input  in_ready, out_valid, out_ch, out_data
  );

  modport slave (
    input  in_valid, in_ch, in_data, out_ready,
    output in_ready, out_valid, out_ch, out_data
  );
endinterface

`default_nettype wire

// File: rtl/cic_integrator_mc_stage.sv
// cic_int_stage -- one integrator stage with a per-channel accumulator bank (rev 1.0).
// Build macro CIC_INT_OVF_EN adds sticky per-channel wrap detection.
`default_nettype none

module cic_int_stage
  import cic_pkg::*;
#(
  parameter int ODW = 40,
  parameter int NCH = 4,
  parameter int CHW = 2
) (
  input  logic           clk_div,
  input  logic           reset_n,
  input  logic           clr_i,
  input  logic           stall_i,
  input  logic [6:0]     w_i,
  input  cic_tok_t       tok_i,
  output cic_tok_t       tok_o,
  output logic [NCH-1:0] ovf_o
);

  localparam logic [TOK_CHW-1:0] NCH_TAG = TOK_CHW'(NCH);

  logic signed [ODW-1:0]    acc_q [NCH];
  cic_tok_t                 tok_q;
  cic_tok_t                 tok_d;
  logic                     hit;
  logic [CHW-1:0]           idx;
  logic signed [TOK_DW-1:0] acc_ext;
  logic signed [TOK_DW-1:0] sum;
  logic signed [TOK_DW-1:0] wrapped;

  // Out-of-range tags never touch the bank and die here as an invalid token.
  always_comb begin
    hit     = tok_i.valid && (tok_i.ch < NCH_TAG);
    idx     = tok_i.ch[CHW-1:0];
    acc_ext = '0;
    if (hit) acc_ext = TOK_DW'(acc_q[idx]);
    sum     = acc_ext + $signed(tok_i.data);
    wrapped = wrap(sum, int'(w_i));
    tok_d       = '0;
    tok_d.valid = hit;
    tok_d.ch    = tok_i.ch;
    tok_d.data  = wrapped;
  end

  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      tok_q <= '0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
    end else if (clr_i) begin
      tok_q <= '0;
      for (int c = 0; c < NCH; c++) acc_q[c] <= '0;
    end else if (!stall_i) begin
      tok_q <= tok_d;
      if (hit) acc_q[idx] <= wrapped[ODW-1:0];
    end
  end

  assign tok_o = tok_q;

`ifdef CIC_INT_OVF_EN
  logic [NCH-1:0] ovf_q;

  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      ovf_q <= '0;
    end else if (clr_i) begin
      ovf_q <= '0;
    end else if (!stall_i && hit && (sum != wrapped)) begin
      ovf_q[idx] <= 1'b1;
    end
  end

  assign ovf_o = ovf_q;
`else
  assign ovf_o = '0;
`endif

endmodule

`default_nettype wire

// File: rtl/cic_integrator_mc.sv
// cic_integrator_mc -- multi-channel, multi-stage CIC integrator section (rev 1.0).
// Build macro CIC_INT_OVF_EN enables the sticky per-channel ovf flags.
`default_nettype none

module cic_integrator_mc
  import cic_pkg::*;
#(
  parameter int IDW  = 16,
  parameter int ODW  = 40,
  parameter int NCH  = 4,
  parameter int NSTG = 3
) (
  input  logic                    clk_div,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic [2:0]              os_sel,
  output logic [NCH-1:0]          ovf,
  cic_integrator_mc_if.slave      bus
);

  localparam int CHW = (NCH > 1) ? $clog2(NCH) : 1;

  logic           first_q;
  logic [2:0]     os_q;
  logic [6:0]     w;
  logic           stall;
  cic_tok_t       in_tok;
  cic_tok_t       stg_in  [NSTG];
  cic_tok_t       tok     [NSTG];
  logic [NCH-1:0] stg_ovf [NSTG];
  logic           unused_tok;

  // first_q marks the reset-exit cycle, when os_sel is captured.
  always_ff @(posedge clk_div or negedge reset_n) begin
    if (!reset_n) begin
      first_q <= 1'b1;
      os_q    <= OS_NONE;
    end else begin
      first_q <= 1'b0;
      if (first_q || clr) os_q <= os_sel;
    end
  end

  assign w = 7'(w_of(first_q ? os_sel : os_q, IDW, NSTG, ODW));

  assign stall        = tok[NSTG-1].valid & ~bus.out_ready;
  assign bus.in_ready = ~stall & ~clr;

  always_comb begin
    in_tok       = '0;
    in_tok.valid = bus.in_valid & bus.in_ready;
    in_tok.ch    = TOK_CHW'(bus.in_ch);
    in_tok.data  = TOK_DW'($signed(bus.in_data));
  end

  for (genvar g = 0; g < NSTG; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign stg_in[g] = in_tok;
    end else begin : g_chain
      assign stg_in[g] = tok[g-1];
    end

    cic_int_stage #(
      .ODW (ODW),
      .NCH (NCH),
      .CHW (CHW)
    ) u_stage (
      .clk_div (clk_div),
      .reset_n (reset_n),
      .clr_i   (clr),
      .stall_i (stall),
      .w_i     (w),
      .tok_i   (stg_in[g]),
      .tok_o   (tok[g]),
      .ovf_o   (stg_ovf[g])
    );
  end

  always_comb begin
    ovf = '0;
    for (int s = 0; s < NSTG; s++) ovf = ovf | stg_ovf[s];
  end

  assign bus.out_valid = tok[NSTG-1].valid;
  assign bus.out_ch    = tok[NSTG-1].ch[CHW-1:0];
  assign bus.out_data  = tok[NSTG-1].data[ODW-1:0];
  assign unused_tok    = ^{tok[NSTG-1].ch, tok[NSTG-1].data};

endmodule

`default_nettype wire

// File: tb/tb_cic_integrator_mc.sv
// tb_cic_integrator_mc -- randomized and directed bench with a per-channel integrator model.
`default_nettype none

module tb_cic_integrator_mc;

  localparam int IDW  = 16;
  localparam int ODW  = 40;
  localparam int NCH  = 4;
  localparam int NSTG = 3;
  localparam int CHW  = 2;

  typedef struct {
    int     ch;
    longint d;
  } exp_t;

  logic           clk_div = 1'b0;
  logic           reset_n;
  logic           clr;
  logic [2:0]     os_sel;
  logic [NCH-1:0] ovf;

  cic_integrator_mc_if #(.IDW(IDW), .ODW(ODW), .CHW(CHW)) bus ();

  cic_integrator_mc #(.IDW(IDW), .ODW(ODW), .NCH(NCH), .NSTG(NSTG)) dut (
    .clk_div (clk_div),
    .reset_n (reset_n),
    .clr     (clr),
    .os_sel  (os_sel),
    .ovf     (ovf),
    .bus     (bus)
  );

  always #5 clk_div = ~clk_div;

  int             n_cmp = 0;
  int             n_err = 0;
  int             cyc   = 0;
  int             fa, fo;
  longint         acc [NCH][NSTG];
  bit [NCH-1:0]   m_ovf;
  int             mw;
  exp_t           exp_q [$];
  longint         got_d [$];
  int             got_c [$];

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic int mw_of(input int os);
    return (os >= 1 && os <= 6) ? IDW + NSTG * os : ODW;
  endfunction

  function automatic longint mwrap(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = v % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < NCH; c++)
      for (int s = 0; s < NSTG; s++) acc[c][s] = 0;
    m_ovf = '0;
    exp_q.delete();
    mw = mw_of(int'(os_sel));
  endfunction

  // Cascade of NSTG running sums per channel, each reduced modulo 2^W.
  function automatic void model_accept(input int ch, input int d);
    logic signed [15:0] ds;
    longint v, s;
    exp_t e;
    ds = 16'(d);
    v  = longint'(ds);
    if (ch >= NCH) return;
    for (int k = 0; k < NSTG; k++) begin
      s = acc[ch][k] + v;
      v = mwrap(s, mw);
      if (v != s) m_ovf[ch] = 1'b1;
      acc[ch][k] = v;
    end
    e.ch = ch;
    e.d  = v;
    exp_q.push_back(e);
  endfunction

  task automatic step(input bit v, input int ch, input int d, input bit ordy, input bit c,
                      output bit accepted);
    @(negedge clk_div);
    bus.in_valid  = v;
    bus.in_ch     = CHW'(ch);
    bus.in_data   = IDW'(d);
    bus.out_ready = ordy;
    clr           = c;
    #1;
    accepted = 1'b0;
    if (bus.out_valid) begin
      if (fo < 0) fo = cyc;
      if (exp_q.size() == 0) begin
        check("spurious_out_valid", 1, 0);
      end else begin
        check("out_ch", bus.out_ch, exp_q[0].ch);
        check("out_data", longint'($signed(bus.out_data)), exp_q[0].d);
        if (ordy) begin
          got_d.push_back(longint'($signed(bus.out_data)));
          got_c.push_back(int'(bus.out_ch));
          void'(exp_q.pop_front());
        end
      end
    end
    if (c) begin
      check("in_ready_during_clr", bus.in_ready, 0);
      model_clear();
    end else if (v && bus.in_ready) begin
      accepted = 1'b1;
      if (fa < 0) fa = cyc;
      model_accept(ch, d);
    end
    cyc++;
  endtask

  task automatic drain();
    bit a;
    for (int i = 0; i < 50 && exp_q.size() != 0; i++) step(0, 0, 0, 1, 0, a);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1, 0, a);
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic check_ovf(input string tag);
`ifdef CIC_INT_OVF_EN
    check(tag, ovf, m_ovf);
`else
    check(tag, ovf, 0);
`endif
  endtask

  task automatic do_clr(input int os);
    bit a;
    os_sel = 3'(os);
    step(0, 0, 0, 1, 1, a);
  endtask

  task automatic impulse(input string tag);
    bit a;
    longint ref_v [4] = '{1, 4, 10, 20};
    got_d.delete();
    got_c.delete();
    fa = -1;
    fo = -1;
    for (int i = 0; i < 4; i++) step(1, 0, 1, 1, 0, a);
    drain();
    check({tag, "_count"}, got_d.size(), 4);
    for (int i = 0; i < 4 && i < got_d.size(); i++) check({tag, "_val"}, got_d[i], ref_v[i]);
    check({tag, "_latency"}, fo - fa, NSTG);
  endtask

  initial begin
    bit a;
    bit saw_neg;
    reset_n       = 1'b0;
    clr           = 1'b0;
    os_sel        = 3'd1;
    bus.in_valid  = 1'b0;
    bus.in_ch     = '0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    fa = -1;
    fo = -1;
    repeat (3) @(negedge clk_div);
    #1;
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_ch", bus.out_ch, 0);
    check("rst_ovf", ovf, 0);
    @(negedge clk_div);
    reset_n = 1'b1;
    model_clear();
    #1;
    check("rst_in_ready", bus.in_ready, 1);

    impulse("impulse");

    // Alternating ch0 (+1) and ch1 (-2) from a cleared state.
    do_clr(1);
    got_d.delete();
    got_c.delete();
    for (int i = 0; i < 8; i++) step(1, i % 2, (i % 2) ? -2 : 1, 1, 0, a);
    drain();
    check("ilv_count", got_d.size(), 8);
    for (int i = 0; i + 1 < got_d.size(); i += 2) begin
      check("ilv_order0", got_c[i], 0);
      check("ilv_order1", got_c[i+1], 1);
      check("ilv_scale", got_d[i+1], -2 * got_d[i]);
    end

    // Back-pressure: five stalled cycles with a sample offered throughout.
    for (int i = 0; i < 4; i++) step(1, 3, int'($urandom_range(0, 65535)), 1, 0, a);
    for (int i = 0; i < 5; i++) begin
      step(1, 3, 99, 0, 0, a);
      check("bp_in_ready", bus.in_ready, 0);
    end
    for (int i = 0; i < 4; i++) step(1, 3, int'($urandom_range(0, 65535)), 1, 0, a);
    drain();

    // Wrap at W = IDW + NSTG for os_sel = 1.
    do_clr(1);
    got_d.delete();
    got_c.delete();
    for (int i = 0; i < 12; i++) step(1, 2, 32767, 1, 0, a);
    drain();
    saw_neg = 1'b0;
    foreach (got_d[i]) if (got_d[i] < 0) saw_neg = 1'b1;
    check("wrap_negative", saw_neg, 1);
    check_ovf("wrap_ovf");

    // clr while stalled and with a sample offered, then a fresh sample of 5.
    for (int i = 0; i < 4; i++) step(1, 0, 7, 1, 0, a);
    step(1, 0, 7, 0, 0, a);
    os_sel = 3'd1;
    step(1, 0, 7, 0, 1, a);
    got_d.delete();
    step(1, 0, 5, 1, 0, a);
    check("clr_out_valid", bus.out_valid, 0);
    check("clr_ovf", ovf, 0);
    drain();
    check("clr_count", got_d.size(), 1);
    if (got_d.size() != 0) check("clr_value", got_d[0], 5);

    // Randomized traffic under a random oversampling code.
    do_clr(int'($urandom_range(0, 7)));
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 3) != 0, int'($urandom_range(0, NCH - 1)),
           int'($urandom_range(0, 65535)), $urandom_range(0, 9) < 7, 0, a);
    drain();
    check_ovf("rand_ovf");

    // Asynchronous reset in mid-stream.
    for (int i = 0; i < 3; i++) step(1, 1, 1000, 1, 0, a);
    @(negedge clk_div);
    #2;
    reset_n      = 1'b0;
    bus.in_valid = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_ovf", ovf, 0);
    os_sel = 3'd1;
    @(negedge clk_div);
    reset_n = 1'b1;
    model_clear();
    #1;
    check("midrst_in_ready", bus.in_ready, 1);
    impulse("reimpulse");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no end, expected finish");
    $fatal(1);
  end

endmodule

`default_nettype wire
